ram_responder: RTL and testbench

- Memory-side responder for the CPU's MAR/MDR memory interface.
- The control unit initiates a read or write by raising mem_en with read or write; this block serves it after a fixed number of wait states and signals completion with a one-cycle ready pulse.
- Replaces the zero-latency RAM model, so the control unit's memory states are exercised against a real handshake.
- Holds a 512 x 32 word array addressed by the 9-bit MAR output.

---
 rtl/ram_responder_pkg.sv | 34 +++
 rtl/ram_responder_if.sv | 53 +++++
 rtl/ram_responder_array.sv | 43 ++++
 rtl/ram_responder.sv | 171 +++++++++++++++++
 tb/tb_ram_responder.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_responder_pkg.sv
// ram_responder_pkg
//   Shared types and constants for the MAR/MDR memory responder.
//   stateT     : responder FSM states (IDLE, WAIT, RESP)
//   opT        : latched operation kind (OP_READ, OP_WRITE)
//   WAIT_CNT_W : width of the wait-state counter (supports 0..15 wait states)
//   satInc     : saturating increment used by the optional statistics counters
package ram_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateT;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } opT;

    localparam int WAIT_CNT_W = 4;
    localparam int STAT_W     = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] satInc(input logic [STAT_W-1:0] value);
        logic [STAT_W-1:0] result;
        if (value == {STAT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(STAT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/ram_responder_if.sv
// ram_responder_if
//   Request/response bundle between the control unit (master) and the
//   memory responder (slave).
//   mem_en, read, write : request strobe and operation qualifiers
//   addr, wdata         : MAR / MDR values for the request
//   rdata               : last completed read data
//   ready               : one-cycle completion pulse
//   busy                : request in flight (acceptance through ready)
//   req_err             : one-cycle malformed-request pulse
//   rd_count, wr_count  : completed-operation counters, only present when
//                         RAM_RESPONDER_STATS_EN is defined
interface ram_responder_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
);
    import ram_responder_pkg::*;

    logic                  mem_en;
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ready;
    logic                  busy;
    logic                  req_err;

`ifdef RAM_RESPONDER_STATS_EN
    logic [STAT_W-1:0]     rd_count;
    logic [STAT_W-1:0]     wr_count;

    modport master (
        output mem_en, read, write, addr, wdata,
        input  rdata, ready, busy, req_err, rd_count, wr_count
    );

    modport slave (
        input  mem_en, read, write, addr, wdata,
        output rdata, ready, busy, req_err, rd_count, wr_count
    );
`else
    modport master (
        output mem_en, read, write, addr, wdata,
        input  rdata, ready, busy, req_err
    );

    modport slave (
        input  mem_en, read, write, addr, wdata,
        output rdata, ready, busy, req_err
    );
`endif

endinterface

// File: rtl/ram_responder_array.sv
// ram_responder_array
//   2**ADDR_WIDTH x DATA_WIDTH word store with synchronous write and a
//   registered, enabled read port. The storage itself is never reset; only
//   the read register returns to zero so the MDR side starts from a known value.
//   clock, reset : rising-edge clock, synchronous active-low reset (read reg only)
//   we, waddr, wdata : write strobe, address, data
//   re, raddr        : read strobe and address
//   rdata_q          : read register, updated only when re is high
module ram_responder_array #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata_q
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] memR [DEPTH];

    // Storage write port; deliberately has no reset.
    always_ff @(posedge clock) begin
        if (we) begin
            memR[waddr] <= wdata;
        end
    end

    // Read register: loads only on a read strobe so it holds the last read.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rdata_q <= {DATA_WIDTH{1'b0}};
        end else if (re) begin
            rdata_q <= memR[raddr];
        end
    end

endmodule

// File: rtl/ram_responder.sv
// ram_responder
//   Memory-side responder for the CPU MAR/MDR interface. A request is
//   accepted in IDLE, held for WAIT_STATES cycles, then answered with a
//   one-cycle ready pulse in RESP. Writes commit on the edge leaving RESP;
//   reads load rdata on the edge entering RESP.
//   clock : rising-edge system clock
//   reset : synchronous active-low reset
//   bus   : ram_responder_if slave modport (request in, response out)
//   Optional macro RAM_RESPONDER_STATS_EN adds saturating rd_count/wr_count.
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic          clock,
    input  logic          reset,
    ram_responder_if.slave bus
);

    localparam logic [WAIT_CNT_W-1:0] LAST_WAIT_C =
        WAIT_CNT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    stateT                  stateR;
    opT                     opR;
    logic [ADDR_WIDTH-1:0]  addrR;
    logic [DATA_WIDTH-1:0]  wdataR;
    logic [WAIT_CNT_W-1:0]  waitCntR;
    logic                   readyR;
    logic                   busyR;
    logic                   reqErrR;

    logic                   validReqS;
    logic                   badReqS;
    logic                   readEnS;
    logic                   writeEnS;
    logic [ADDR_WIDTH-1:0]  raddrS;
    logic [DATA_WIDTH-1:0]  rdataS;

    assign validReqS = bus.mem_en & (bus.read ^ bus.write);
    assign badReqS   = bus.mem_en & ~(bus.read ^ bus.write);

    // Read strobe fires on the edge that enters RESP. With zero wait states
    // that edge is the acceptance edge, so the address comes straight off the bus.
    always_comb begin
        readEnS = 1'b0;
        raddrS  = addrR;
        case (stateR)
            IDLE: begin
                raddrS = bus.addr;
                if (validReqS && (WAIT_STATES == 0)) begin
                    readEnS = bus.read;
                end else begin
                    readEnS = 1'b0;
                end
            end
            WAIT: begin
                if (waitCntR == LAST_WAIT_C) begin
                    readEnS = (opR == OP_READ);
                end else begin
                    readEnS = 1'b0;
                end
            end
            RESP: begin
                readEnS = 1'b0;
            end
            default: begin
                readEnS = 1'b0;
            end
        endcase
    end

    // Gating with reset keeps a write from landing when reset hits during RESP.
    assign writeEnS = (stateR == RESP) && (opR == OP_WRITE) && reset;

    // Responder FSM with registered handshake outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stateR   <= IDLE;
            opR      <= OP_READ;
            addrR    <= {ADDR_WIDTH{1'b0}};
            wdataR   <= {DATA_WIDTH{1'b0}};
            waitCntR <= {WAIT_CNT_W{1'b0}};
            readyR   <= 1'b0;
            busyR    <= 1'b0;
            reqErrR  <= 1'b0;
        end else begin
            readyR  <= 1'b0;
            reqErrR <= 1'b0;
            case (stateR)
                IDLE: begin
                    waitCntR <= {WAIT_CNT_W{1'b0}};
                    if (validReqS) begin
                        addrR  <= bus.addr;
                        wdataR <= bus.wdata;
                        opR    <= bus.write ? OP_WRITE : OP_READ;
                        busyR  <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            stateR <= RESP;
                            readyR <= 1'b1;
                        end else begin
                            stateR <= WAIT;
                        end
                    end else if (badReqS) begin
                        reqErrR <= 1'b1;
                    end
                end
                WAIT: begin
                    if (waitCntR == LAST_WAIT_C) begin
                        stateR   <= RESP;
                        readyR   <= 1'b1;
                        waitCntR <= {WAIT_CNT_W{1'b0}};
                    end else begin
                        waitCntR <= waitCntR + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                RESP: begin
                    stateR <= IDLE;
                    busyR  <= 1'b0;
                end
                default: begin
                    stateR <= IDLE;
                    busyR  <= 1'b0;
                end
            endcase
        end
    end

    ram_responder_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) uArray (
        .clock   (clock),
        .reset   (reset),
        .we      (writeEnS),
        .waddr   (addrR),
        .wdata   (wdataR),
        .re      (readEnS),
        .raddr   (raddrS),
        .rdata_q (rdataS)
    );

    assign bus.rdata   = rdataS;
    assign bus.ready   = readyR;
    assign bus.busy    = busyR;
    assign bus.req_err = reqErrR;

`ifdef RAM_RESPONDER_STATS_EN
    logic [STAT_W-1:0] rdCountR;
    logic [STAT_W-1:0] wrCountR;

    // Completed-operation counters, bumped once per ready pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rdCountR <= {STAT_W{1'b0}};
            wrCountR <= {STAT_W{1'b0}};
        end else if (readyR) begin
            if (opR == OP_READ) begin
                rdCountR <= satInc(rdCountR);
            end else begin
                wrCountR <= satInc(wrCountR);
            end
        end
    end

    assign bus.rd_count = rdCountR;
    assign bus.wr_count = wrCountR;
`endif

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder
//   Two responders share one clock/reset: dutA with two wait states and
//   dutB with none. Stimulus pushes expected responses into per-DUT queues;
//   a monitor pops and compares on every ready pulse.
module tb_ram_responder;
    import ram_responder_pkg::*;

    localparam int WS_A = 2;
    localparam int WS_B = 0;

    typedef struct {
        logic        isRead;
        logic [31:0] data;
    } expT;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    expT  qA[$];
    expT  qB[$];

    always #5 clock = ~clock;

    ram_responder_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) ifA ();
    ram_responder_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) ifB ();

    ram_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(WS_A)) dutA (
        .clock (clock),
        .reset (reset),
        .bus   (ifA.slave)
    );

    ram_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(WS_B)) dutB (
        .clock (clock),
        .reset (reset),
        .bus   (ifB.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic en, input logic rd, input logic wr,
                         input logic [8:0] a, input logic [31:0] d);
        if (sel == 0) begin
            ifA.mem_en = en; ifA.read = rd; ifA.write = wr; ifA.addr = a; ifA.wdata = d;
        end else begin
            ifB.mem_en = en; ifB.read = rd; ifB.write = wr; ifB.addr = a; ifB.wdata = d;
        end
    endtask

    function automatic logic getReady(input int sel);
        return (sel == 0) ? ifA.ready : ifB.ready;
    endfunction

    function automatic logic getBusy(input int sel);
        return (sel == 0) ? ifA.busy : ifB.busy;
    endfunction

    function automatic logic getErr(input int sel);
        return (sel == 0) ? ifA.req_err : ifB.req_err;
    endfunction

    function automatic logic [31:0] getRdata(input int sel);
        return (sel == 0) ? ifA.rdata : ifB.rdata;
    endfunction

    task automatic pushExp(input int sel, input logic isRead, input logic [31:0] data);
        expT e;
        e.isRead = isRead;
        e.data   = data;
        if (sel == 0) qA.push_back(e); else qB.push_back(e);
    endtask

    // One complete transaction; junk (a valid-looking write elsewhere) is
    // driven while busy and dropped the moment ready is seen.
    task automatic issue(input int sel, input logic rd, input logic wr,
                         input logic [8:0] a, input logic [31:0] d, input logic [31:0] expRd);
        int ws;
        int n;
        ws = (sel == 0) ? WS_A : WS_B;
        n  = 0;
        @(posedge clock); #1;
        drive(sel, 1'b1, rd, wr, a, d);
        pushExp(sel, rd, expRd);
        @(posedge clock); #1;
        drive(sel, 1'b1, 1'b0, 1'b1, a ^ 9'h0F0, ~d);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (getReady(sel)) begin
                n = i;
                break;
            end
        end
        drive(sel, 1'b0, 1'b0, 1'b0, a, d);
        check($sformatf("ready_latency dut%0d", sel), 32'(n), 32'(ws + 1));
        check($sformatf("busy_at_ready dut%0d", sel), 32'(getBusy(sel)), 32'd1);
        @(negedge clock);
        check($sformatf("ready_width dut%0d", sel), 32'(getReady(sel)), 32'd0);
        check($sformatf("busy_after dut%0d", sel), 32'(getBusy(sel)), 32'd0);
    endtask

    // Malformed request: expect a one-cycle req_err, no busy, no ready.
    task automatic badReq(input int sel, input logic rd, input logic wr,
                          input logic [8:0] a, input logic [31:0] d, input logic [31:0] holdRd);
        @(posedge clock); #1;
        drive(sel, 1'b1, rd, wr, a, d);
        @(posedge clock); #1;
        drive(sel, 1'b0, 1'b0, 1'b0, a, d);
        @(negedge clock);
        check("req_err_pulse", 32'(getErr(sel)), 32'd1);
        check("req_err_busy", 32'(getBusy(sel)), 32'd0);
        check("req_err_ready", 32'(getReady(sel)), 32'd0);
        @(negedge clock);
        check("req_err_width", 32'(getErr(sel)), 32'd0);
        check("req_err_rdata_hold", getRdata(sel), holdRd);
    endtask

    task automatic popCheck(input int sel);
        expT e;
        if ((sel == 0 && qA.size() == 0) || (sel == 1 && qB.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ready dut%0d: got ready=1, required no pending request", sel);
        end else begin
            if (sel == 0) e = qA.pop_front(); else e = qB.pop_front();
            if (e.isRead) begin
                check($sformatf("rdata dut%0d", sel), getRdata(sel), e.data);
            end
        end
    endtask

    // Scoreboard monitor.
    initial begin
        forever begin
            @(negedge clock);
            if (ifA.ready === 1'b1) popCheck(0);
            if (ifB.ready === 1'b1) popCheck(1);
        end
    end

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, required finish within 100000 time units");
        $fatal(1);
    end

    initial begin
        int seen;
        drive(0, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("reset_rdata", ifA.rdata, 32'h0);
        check("reset_ready", 32'(ifA.ready), 32'd0);
        check("reset_busy", 32'(ifA.busy), 32'd0);
        check("reset_req_err", 32'(ifA.req_err), 32'd0);
        check("reset_rdata_b", ifB.rdata, 32'h0);

        // Write then read back with two wait states.
        issue(0, 1'b0, 1'b1, 9'h01F, 32'hDEADBEEF, 32'h0);
        issue(0, 1'b1, 1'b0, 9'h01F, 32'h0, 32'hDEADBEEF);
        @(negedge clock);
        check("rdata_hold", ifA.rdata, 32'hDEADBEEF);

        // Malformed requests must not touch the array.
        issue(0, 1'b0, 1'b1, 9'h005, 32'hA5A50005, 32'h0);
        badReq(0, 1'b1, 1'b1, 9'h005, 32'h0BADF00D, 32'hDEADBEEF);
        badReq(0, 1'b0, 1'b0, 9'h005, 32'h0BADF00D, 32'hDEADBEEF);
        issue(0, 1'b1, 1'b0, 9'h005, 32'h0, 32'hA5A50005);

        // Reset during WAIT abandons the write.
        issue(0, 1'b0, 1'b1, 9'h1FF, 32'hCAFE01FF, 32'h0);
        @(posedge clock); #1;
        drive(0, 1'b1, 1'b0, 1'b1, 9'h1FF, 32'h12345678);
        @(posedge clock); #1;
        drive(0, 1'b0, 1'b0, 1'b0, 9'h1FF, 32'h0);
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("abort_busy", 32'(ifA.busy), 32'd0);
        check("abort_rdata", ifA.rdata, 32'h0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (ifA.ready) seen++;
            @(negedge clock);
        end
        check("abort_no_ready", 32'(seen), 32'd0);
        issue(0, 1'b1, 1'b0, 9'h1FF, 32'h0, 32'hCAFE01FF);

        // Zero wait states, request held high across two reads.
        issue(1, 1'b0, 1'b1, 9'h000, 32'h0000AAAA, 32'h0);
        issue(1, 1'b0, 1'b1, 9'h001, 32'h1111BBBB, 32'h0);
        @(posedge clock); #1;
        drive(1, 1'b1, 1'b1, 1'b0, 9'h000, 32'h0);
        pushExp(1, 1'b1, 32'h0000AAAA);
        pushExp(1, 1'b1, 32'h1111BBBB);
        @(posedge clock); #1;
        drive(1, 1'b1, 1'b1, 1'b0, 9'h0AA, 32'h0);
        @(negedge clock);
        check("b2b_ready1", 32'(ifB.ready), 32'd1);
        @(posedge clock); #1;
        drive(1, 1'b1, 1'b1, 1'b0, 9'h001, 32'h0);
        @(negedge clock);
        check("b2b_gap_ready", 32'(ifB.ready), 32'd0);
        check("b2b_gap_busy", 32'(ifB.busy), 32'd0);
        @(posedge clock); #1;
        drive(1, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
        @(negedge clock);
        check("b2b_ready2", 32'(ifB.ready), 32'd1);
        @(negedge clock);
        check("b2b_ready2_width", 32'(ifB.ready), 32'd0);

`ifdef RAM_RESPONDER_STATS_EN
        @(posedge clock); #1 reset = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        issue(0, 1'b0, 1'b1, 9'h010, 32'h00000010, 32'h0);
        issue(0, 1'b0, 1'b1, 9'h011, 32'h00000011, 32'h0);
        issue(0, 1'b0, 1'b1, 9'h012, 32'h00000012, 32'h0);
        issue(0, 1'b1, 1'b0, 9'h010, 32'h0, 32'h00000010);
        issue(0, 1'b1, 1'b0, 9'h012, 32'h0, 32'h00000012);
        check("wr_count", 32'(ifA.wr_count), 32'd3);
        check("rd_count", 32'(ifA.rd_count), 32'd2);
        force dutA.wrCountR = 16'hFFFF;
        @(posedge clock); #1;
        release dutA.wrCountR;
        issue(0, 1'b0, 1'b1, 9'h013, 32'h00000013, 32'h0);
        check("wr_count_sat", 32'(ifA.wr_count), 32'h0000FFFF);
        check("rd_count_after_sat", 32'(ifA.rd_count), 32'd2);
`endif

        repeat (2) @(negedge clock);
        check("scoreboard_drained", 32'(qA.size() + qB.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
